// File: rtl/node_sequencer_pkg.sv
// node_pkg: constants, sample type and sequencer state encoding.
// It is shared by node_sequencer, its sample buffer and the node datapath.
package node_pkg;

    localparam int N_INPUTS = 64;   // samples per pass and buffer depth
    localparam int DATA_W   = 16;   // fixed-point sample width
    localparam int IDX_W    = 7;    // width of cnt_val and of the write pointer
    localparam int OUT_W    = 3;    // node activation output width

    typedef logic [DATA_W-1:0] sample_t;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESULT = 3'd4
    } seq_state_e;

endpackage

// File: rtl/node_sequencer_if.sv
// node_sequencer_if: the sample input stream and the result output stream.
// Both are valid/ready handshakes.
//   in_valid/in_ready/in_data    : samples into the sequencer
//   res_valid/res_ready/res_data : node activation result out of the sequencer
// master = environment side (upstream source plus downstream sink).
// slave  = node_sequencer side.
interface node_sequencer_if;
    import node_pkg::*;

    logic             in_valid;
    logic             in_ready;
    sample_t          in_data;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data
    );

endinterface

// File: rtl/node_sequencer_sample_buffer.sv
// sample_buffer: N_INPUTS x DATA_W register array with one write port and
// full parallel read-out. Asynchronous active-low reset clears every entry.
//   clk, n_rst : clock, async active-low reset
//   we_i       : write enable
//   widx_i     : write index (entries 0..N_INPUTS-1)
//   wdata_i    : write data
//   data_o     : all entries, index-aligned
module sample_buffer
    import node_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  sample_t          wdata_i,
    output sample_t          data_o [N_INPUTS]
);

    sample_t mem_q [N_INPUTS];

    // Decoded write: compare the full index so no pointer bit is left unused.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < N_INPUTS; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (we_i && (widx_i == IDX_W'(i))) mem_q[i] <= wdata_i;
            end
        end
    end

    assign data_o = mem_q;

endmodule

// File: rtl/node_sequencer.sv
// node_sequencer: stages N_INPUTS samples and drives one node MAC pass.
// It then returns the node activation over a valid/ready handshake.
//   clk, n_rst : clock, async active-low reset
//   flush      : synchronous abort back to LOAD; the partial pass is dropped
//   bus        : sample stream in, result stream out (slave modport)
//   data_out   : buffer contents, wired to node data_in
//   cnt_val    : MAC step index (acc_idx in ACCUM, otherwise 0)
//   start      : node hold control, 0 = accumulate, 1 = hold
//   reset_acc  : node accumulator clear, high only in CLEAR
//   node_out   : node activation, captured at the end of SETTLE
//   busy       : high from CLEAR through RESULT
module node_sequencer
    import node_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush,
    node_sequencer_if.slave  bus,
    output sample_t          data_out [N_INPUTS],
    output logic [IDX_W-1:0] cnt_val,
    output logic             start,
    output logic             reset_acc,
    input  logic [OUT_W-1:0] node_out,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] wptr_q, wptr_d;
    logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
    logic [OUT_W-1:0] res_data_q;
    logic             buf_we;
    logic             res_load;

    sample_buffer u_buf (
        .clk     (clk),
        .n_rst   (n_rst),
        .we_i    (buf_we),
        .widx_i  (wptr_q),
        .wdata_i (bus.in_data),
        .data_o  (data_out)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_LOAD;
            wptr_q     <= '0;
            acc_idx_q  <= '0;
            res_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            acc_idx_q <= acc_idx_d;
            if (res_load) res_data_q <= node_out;
        end
    end

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        acc_idx_d    = acc_idx_q;
        buf_we       = 1'b0;
        res_load     = 1'b0;
        bus.in_ready = 1'b0;
        bus.res_valid = 1'b0;
        start        = 1'b1;
        reset_acc    = 1'b0;
        cnt_val      = '0;

        case (state_q)
            ST_LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    buf_we = 1'b1;
                    if (wptr_q == LAST_IDX) begin
                        wptr_d  = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                reset_acc = 1'b1;
                acc_idx_d = '0;
                state_d   = ST_ACCUM;
            end
            ST_ACCUM: begin
                start   = 1'b0;
                cnt_val = acc_idx_q;
                if (acc_idx_q == LAST_IDX) begin
                    acc_idx_d = '0;
                    state_d   = ST_SETTLE;
                end else begin
                    acc_idx_d = acc_idx_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                res_load = 1'b1;
                state_d  = ST_RESULT;
            end
            ST_RESULT: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase

        // Abort wins over every transition. A sample offered in the same
        // cycle is dropped, and a result handshake in the same cycle simply
        // completes.
        if (flush) begin
            state_d   = ST_LOAD;
            wptr_d    = '0;
            acc_idx_d = '0;
            buf_we    = 1'b0;
            res_load  = 1'b0;
        end
    end

    assign bus.res_data = res_data_q;
    assign busy         = (state_q != ST_LOAD);

endmodule

// File: doc/node_sequencer.md
# node_sequencer

Control and data-staging block that drives one neural-network `node` MAC datapath. It accepts 64 fixed-point input samples over a valid/ready stream and holds them in a 64-entry buffer presented to the node's `data_in` array. It then sequences the node's `reset_acc`, `start` and `cnt_val` controls through one full accumulation pass and returns the node's 3-bit activation output over a second valid/ready handshake. Coefficients are supplied to the node from elsewhere; this block does not drive them.

## Interface
Parameters:
- N_INPUTS, 64, samples per pass and buffer depth
- DATA_W, 16, fixed-point sample width
- IDX_W, 7, width of `cnt_val` and of the write pointer
- OUT_W, 3, width of the node activation output

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort; returns to LOAD and discards the partial pass
- in_valid  in  1  upstream sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_W  sample value
- data_out  out  DATA_W x N_INPUTS  buffer contents, wired to node `data_in`
- cnt_val  out  IDX_W  index the node uses for the current MAC step
- start  out  1  node hold control: 0 = accumulate, 1 = hold
- reset_acc  out  1  node accumulator clear
- node_out  in  OUT_W  node activation result
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  OUT_W  registered result
- busy  out  1  high in CLEAR, ACCUM, SETTLE or RESULT

## Operation
- States are LOAD, CLEAR, ACCUM, SETTLE and RESULT.
- LOAD:
  - `in_ready`=1.
  - On `in_valid && in_ready`, `in_data` is written to `buf[wptr]` and `wptr` increments.
  - When the write is to index N_INPUTS-1, `wptr` wraps to 0 and the next state is CLEAR.
- CLEAR (1 cycle): `reset_acc`=1, `start`=1, then go to ACCUM with `acc_idx`=0.
- ACCUM (N_INPUTS cycles):
  - `start`=0 and `cnt_val`=`acc_idx`.
  - `acc_idx` increments each cycle.
  - After the cycle with `acc_idx`=N_INPUTS-1, go to SETTLE.
- SETTLE (1 cycle): `start`=1. At the end of the cycle, `res_data` <= `node_out`.
- RESULT:
  - `res_valid`=1 and `res_data` stays stable until `res_valid && res_ready`.
  - On that handshake, go to LOAD.
- Outside ACCUM: `cnt_val`=0 and `start`=1. `reset_acc` is 0 except in CLEAR.
- `data_out` always reflects the buffer. The buffer is written only in LOAD, so it is stable for the whole computation.
- `flush` has priority over every transition:
  - Next state is LOAD; `wptr`, `acc_idx` and `res_valid` go to 0.
  - Buffer contents are retained and are overwritten by the next load.
- `flush` in the same cycle as an input handshake: the sample is discarded and `wptr` goes to 0.
- `flush` in the same cycle as a result handshake: the result is treated as consumed. No double delivery.

## Timing
- Reset values:
  - state=LOAD, `in_ready`=1, `wptr`=0, `acc_idx`=0, all buffer entries 0.
  - `cnt_val`=0, `start`=1, `reset_acc`=0.
  - `res_valid`=0, `res_data`=0, `busy`=0.
- Reset asserted mid-pass aborts immediately (asynchronous). The pass is not resumed.
- Latency, with the final sample accepted at edge k:
  - CLEAR in cycle k+1.
  - ACCUM in cycles k+2..k+65, with `cnt_val` 0..63.
  - SETTLE in cycle k+66.
  - `res_valid`=1 from cycle k+67.
- Throughput: one pass per 64 load cycles + 66 compute cycles + at least 1 result cycle.
- Back-pressure: `in_ready`=0 throughout CLEAR to RESULT. A gap in `in_valid` during LOAD stalls `wptr` with no effect on buffer contents.
- `res_ready` held high in RESULT: handshake on the first RESULT cycle and `in_ready`=1 on the next cycle.
- `res_ready` high outside RESULT has no effect.

## Structure
- Package `node_pkg` holds:
  - constants N_INPUTS, DATA_W, IDX_W and OUT_W;
  - `typedef enum logic [2:0]` for the sequencer states;
  - the sample type `logic [DATA_W-1:0]`.
- `node` also uses this package.
- Sub-module `sample_buffer` is a 64 x DATA_W register array:
  - write enable, write index and write data inputs;
  - full parallel read-out;
  - asynchronous reset to 0.
- FSM and counters stay in `node_sequencer`.

## Test plan
- Reset then load 64 samples, value i at index i, `in_valid` held high:
  - `in_ready` falls after edge 64.
  - `reset_acc`=1 for exactly one cycle.
  - `cnt_val` steps 0..63 with `start`=0.
  - `res_valid` rises exactly 67 cycles after the last handshake.
  - `res_data` equals `node_out` sampled in SETTLE.
- `res_ready` low for 10 cycles in RESULT:
  - `res_valid` and `res_data` stay stable and `in_ready` stays 0.
  - After the handshake, `in_ready`=1 on the next cycle.
- Load with random `in_valid` gaps: buffer contents match the accepted order and `wptr` never advances on an idle cycle.
- `flush` at sample 30 of a load, then 64 new samples: the pass uses only the new samples for indices 0..63.
- `flush` during ACCUM with `cnt_val`=20: next cycle is LOAD, `cnt_val`=0, `start`=1, and `res_valid` never asserts for the aborted pass.
- `n_rst` pulsed during SETTLE: all outputs take their reset values immediately, and a following full load produces a normal result.
